cpu_core: RTL and testbench

Minimal 8-bit accumulator-style CPU core with a 16×8 unified memory, sequenced by two dual-rail phase tokens (fetch `ph0`, execute `ph1`) and return-to-zero handshakes. It is the top-level compute block of the asynchronous-style CPU, implemented as a single-clock synchronous design. It fetches one instruction per `ph0` token, executes it on the `ph1` token, and hands the decoded instruction to a downstream stage via `instr_ack_before`/`instr_ack_next`.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cpu_mem.sv | 41 ++++
 rtl/cpu_core.sv | 176 +++++++++++++++++
 tb/tb_cpu_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU core: widths, dual-rail token
// codes, opcode nibbles, FSM state codes and a small opcode decoder.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;

    // Dual-rail phase token codes; anything other than DR_REQ is a spacer.
    localparam logic [1:0] DR_REQ  = 2'b10;
    localparam logic [1:0] DR_NULL = 2'b00;

    // Opcode nibbles (instruction byte [7:4]).
    localparam logic [3:0] OP_LOAD_A = 4'b1000;
    localparam logic [3:0] OP_LOAD_B = 4'b1001;
    localparam logic [3:0] OP_READ_A = 4'b0100;

    // FSM state codes, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE          = 3'd0;
    localparam state_t ST_FETCH         = 3'd1;
    localparam state_t ST_WAIT_PH0_NULL = 3'd2;
    localparam state_t ST_WAIT_PH1      = 3'd3;
    localparam state_t ST_EXEC          = 3'd4;
    localparam state_t ST_HOLD          = 3'd5;
    localparam state_t ST_WAIT_RELEASE  = 3'd6;

    typedef enum logic [1:0] {
        ACT_NOP     = 2'd0,
        ACT_LOAD_A  = 2'd1,
        ACT_LOAD_B  = 2'd2,
        ACT_STORE_A = 2'd3
    } exec_act_e;

    // Map an opcode nibble onto the action taken in EXEC; unknown codes are NOPs.
    function automatic exec_act_e decode_op(input logic [3:0] op);
        exec_act_e act;
        case (op)
            OP_LOAD_A: act = ACT_LOAD_A;
            OP_LOAD_B: act = ACT_LOAD_B;
            OP_READ_A: act = ACT_STORE_A;
            default:   act = ACT_NOP;
        endcase
        return act;
    endfunction

    // True only for the request code; spacer and illegal codes count as null.
    function automatic logic is_req(input logic [1:0] tok);
        return (tok == DR_REQ);
    endfunction

endpackage

// File: rtl/cpu_mem.sv
// -----------------------------------------------------------------------------
// cpu_mem
// Unified 16x8 program/data memory. Two asynchronous read ports (instruction
// fetch and operand fetch) and one synchronous write port. Contents are never
// reset so a preloaded program survives a core reset.
//   clk_i      : clock
//   we_i       : write enable (sampled on rising edge)
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr0_i   : fetch read address     -> rdata0_o
//   raddr1_i   : operand read address   -> rdata1_o
// -----------------------------------------------------------------------------
module cpu_mem
    import cpu_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int WORD_W    = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    output logic [WORD_W-1:0] rdata0_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [WORD_W-1:0] rdata1_o
);

    logic [WORD_W-1:0] memoria [0:MEM_DEPTH-1];

    // Synchronous write port; no reset on the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memoria[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = memoria[raddr0_i];
    assign rdata1_o = memoria[raddr1_i];

endmodule

// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core
// 8-bit accumulator CPU sequenced by dual-rail phase tokens with
// return-to-zero handshakes: ph0 fetches an instruction, ph1 executes it, and
// the decoded instruction is offered downstream on instr_ack_before.
//   clk              : clock
//   rst_n            : synchronous active-low reset (memory retained)
//   ph0 / ph1        : fetch / execute dual-rail tokens (2'b10 = request)
//   addr             : fetch address
//   instruction      : registered {ir, operand}
//   instr_ack_next   : downstream acknowledge
//   ctrl_ack         : execute-phase acknowledge
//   mem_addr_ack     : fetch-phase acknowledge
//   instr_ack_before : instruction valid to downstream
// -----------------------------------------------------------------------------
module cpu_core
    import cpu_pkg::*;
#(
    parameter int MEM_DEPTH = 16,
    parameter int WORD_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          ph0,
    input  logic [1:0]          ph1,
    input  logic [ADDR_W-1:0]   addr,
    output logic [2*WORD_W-1:0] instruction,
    input  logic                instr_ack_next,
    output logic                ctrl_ack,
    output logic                mem_addr_ack,
    output logic                instr_ack_before
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   reg_a_q, reg_a_d;
    logic [WORD_W-1:0]   reg_b_q, reg_b_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [WORD_W-1:0]   operand_q, operand_d;
    logic                mem_addr_ack_q, mem_addr_ack_d;
    logic                ctrl_ack_q, ctrl_ack_d;
    logic                instr_ack_before_q, instr_ack_before_d;
    logic [2*WORD_W-1:0] instruction_q, instruction_d;

    logic [WORD_W-1:0]   fetch_data_s;
    logic [WORD_W-1:0]   opnd_data_s;
    logic                mem_we_s;
    exec_act_e           act_s;

    assign act_s = decode_op(ir_q[7:4]);
    // Store only in EXEC, and never on a reset edge so an aborted READ_A
    // cannot corrupt memory.
    assign mem_we_s = rst_n && (state_q == ST_EXEC) && (act_s == ACT_STORE_A);

    cpu_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .WORD_W    (WORD_W)
    ) memoria (
        .clk_i    (clk),
        .we_i     (mem_we_s),
        .waddr_i  (ir_q[3:0]),
        .wdata_i  (reg_a_q),
        .raddr0_i (addr),
        .rdata0_o (fetch_data_s),
        .raddr1_i (ir_q[3:0]),
        .rdata1_o (opnd_data_s)
    );

    // Next-state and datapath update logic for the handshake FSM.
    always_comb begin
        state_d            = state_q;
        reg_a_d            = reg_a_q;
        reg_b_d            = reg_b_q;
        ir_d               = ir_q;
        operand_d          = operand_q;
        mem_addr_ack_d     = mem_addr_ack_q;
        ctrl_ack_d         = ctrl_ack_q;
        instr_ack_before_d = instr_ack_before_q;

        case (state_q)
            ST_IDLE: begin
                // ph1 is deliberately ignored here; execute waits for WAIT_PH1.
                if (is_req(ph0)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_d           = fetch_data_s;
                mem_addr_ack_d = 1'b1;
                state_d        = ST_WAIT_PH0_NULL;
            end
            ST_WAIT_PH0_NULL: begin
                // Operand tracks mem[M] while waiting, so it is fresh at exec.
                operand_d = opnd_data_s;
                if (!is_req(ph0)) begin
                    mem_addr_ack_d = 1'b0;
                    state_d        = ST_WAIT_PH1;
                end else begin
                    state_d = ST_WAIT_PH0_NULL;
                end
            end
            ST_WAIT_PH1: begin
                if (is_req(ph1)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT_PH1;
                end
            end
            ST_EXEC: begin
                case (act_s)
                    ACT_LOAD_A: reg_a_d = operand_q;
                    ACT_LOAD_B: reg_b_d = operand_q;
                    default:    reg_a_d = reg_a_q;
                endcase
                ctrl_ack_d         = 1'b1;
                instr_ack_before_d = 1'b1;
                state_d            = ST_HOLD;
            end
            ST_HOLD: begin
                if (instr_ack_next) begin
                    instr_ack_before_d = 1'b0;
                    state_d            = ST_WAIT_RELEASE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT_RELEASE: begin
                // Both the execute token and the downstream ack must return
                // to zero before the cycle is considered finished.
                if (!is_req(ph1) && !instr_ack_next) begin
                    ctrl_ack_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        instruction_d = {ir_d, operand_d};
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            reg_a_q            <= {WORD_W{1'b0}};
            reg_b_q            <= {WORD_W{1'b0}};
            ir_q               <= {WORD_W{1'b0}};
            operand_q          <= {WORD_W{1'b0}};
            mem_addr_ack_q     <= 1'b0;
            ctrl_ack_q         <= 1'b0;
            instr_ack_before_q <= 1'b0;
            instruction_q      <= {(2*WORD_W){1'b0}};
        end else begin
            state_q            <= state_d;
            reg_a_q            <= reg_a_d;
            reg_b_q            <= reg_b_d;
            ir_q               <= ir_d;
            operand_q          <= operand_d;
            mem_addr_ack_q     <= mem_addr_ack_d;
            ctrl_ack_q         <= ctrl_ack_d;
            instr_ack_before_q <= instr_ack_before_d;
            instruction_q      <= instruction_d;
        end
    end

    assign instruction      = instruction_q;
    assign ctrl_ack         = ctrl_ack_q;
    assign mem_addr_ack     = mem_addr_ack_q;
    assign instr_ack_before = instr_ack_before_q;

endmodule

// File: tb/tb_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_cpu_core
// Self-checking bench for cpu_core: directed program from the test plan,
// token corner cases, mid-operation reset, then randomized programs checked
// against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ph0 = 2'b00;
    logic [1:0]  ph1 = 2'b00;
    logic [3:0]  addr = 4'h0;
    logic [15:0] instruction;
    logic        instr_ack_next = 1'b0;
    logic        ctrl_ack;
    logic        mem_addr_ack;
    logic        instr_ack_before;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] mem_m [0:15];
    logic [7:0] a_m = 8'h00;
    logic [7:0] b_m = 8'h00;

    cpu_core #(.MEM_DEPTH(16), .WORD_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ph0              (ph0),
        .ph1              (ph1),
        .addr             (addr),
        .instruction      (instruction),
        .instr_ack_next   (instr_ack_next),
        .ctrl_ack         (ctrl_ack),
        .mem_addr_ack     (mem_addr_ack),
        .instr_ack_before (instr_ack_before)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return mem_addr_ack;
            1:       return ctrl_ack;
            default: return instr_ack_before;
        endcase
    endfunction

    // Wait (bounded) for a handshake output to reach a level, then compare.
    task automatic wait_sig(input string tag, input int sel, input logic val);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pick(sel) === val) break;
        end
        check_eq(tag, {15'd0, pick(sel)}, {15'd0, val});
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] v);
        dut.memoria.memoria[a] = v;
        mem_m[a] = v;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            check_eq(tag, {8'd0, dut.memoria.memoria[i]}, {8'd0, mem_m[i]});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_outs"}, {13'd0, mem_addr_ack, ctrl_ack, instr_ack_before}, 16'h0000);
        check_eq({tag, "_instr"}, instruction, 16'h0000);
        check_eq({tag, "_regs"}, {dut.reg_a_q, dut.reg_b_q}, 16'h0000);
        check_eq({tag, "_state"}, {13'd0, dut.state_q}, {13'd0, cpu_pkg::ST_IDLE});
    endtask

    // One full fetch/execute handshake at address a, checked against the model.
    // early_ph1: raise ph1 together with ph0. abort: reset while in HOLD.
    task automatic do_instr(input logic [3:0] a, input bit early_ph1, input bit abort);
        logic [7:0] ir_e, op_e;
        logic [1:0] spacer;
        ir_e = mem_m[a];
        op_e = mem_m[ir_e[3:0]];
        addr = a;
        ph0  = 2'b10;
        if (early_ph1) ph1 = 2'b10;
        wait_sig("maa_rise", 0, 1'b1);
        check_eq("ctrl_before_exec", {15'd0, ctrl_ack}, 16'h0000);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        spacer = 2'(($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11));
        ph0 = spacer;
        wait_sig("maa_fall", 0, 1'b0);
        check_eq("ctrl_wait_ph1", {15'd0, ctrl_ack}, 16'h0000);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ph1 = 2'b10;
        // Reference: instruction-level semantics.
        case (ir_e[7:4])
            4'b1000: a_m = op_e;
            4'b1001: b_m = op_e;
            4'b0100: mem_m[ir_e[3:0]] = a_m;
            default: ;
        endcase
        wait_sig("ctrl_rise", 1, 1'b1);
        check_eq("iab_rise", {15'd0, instr_ack_before}, 16'h0001);
        check_eq("instruction", instruction, {ir_e, op_e});
        check_eq("reg_a", {8'd0, dut.reg_a_q}, {8'd0, a_m});
        check_eq("reg_b", {8'd0, dut.reg_b_q}, {8'd0, b_m});
        check_eq("mem_store", {8'd0, dut.memoria.memoria[ir_e[3:0]]}, {8'd0, mem_m[ir_e[3:0]]});
        if (abort) begin
            rst_n = 1'b0;
            ph1   = 2'b00;
            repeat (3) @(negedge clk);
            a_m = 8'h00;
            b_m = 8'h00;
            check_reset_state("midop_rst");
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            instr_ack_next = 1'b1;
            wait_sig("iab_fall", 2, 1'b0);
            repeat (2) @(negedge clk);
            check_eq("ctrl_hold_ph1", {15'd0, ctrl_ack}, 16'h0001);
            ph1 = 2'b00;
            repeat (2) @(negedge clk);
            check_eq("ctrl_hold_ack", {15'd0, ctrl_ack}, 16'h0001);
            instr_ack_next = 1'b0;
            wait_sig("ctrl_fall", 1, 1'b0);
        end
    endtask

    initial begin
        // Preload memory while reset is held.
        for (int i = 0; i < 16; i++) poke(4'(i), 8'h00);
        poke(4'h0, 8'h8F);
        poke(4'hF, 8'hCC);
        poke(4'h1, 8'h47);
        poke(4'h2, 8'h97);
        poke(4'h3, 8'hF5);
        poke(4'h5, 8'h3C);
        poke(4'h4, 8'h42);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check_mem("reset_mem");
        rst_n = 1'b1;
        @(negedge clk);

        // Test-plan program: LOAD_A, READ_A, LOAD_B.
        do_instr(4'h0, 1'b0, 1'b0);
        check_eq("loadA_a", {8'd0, a_m}, 16'h00CC);
        do_instr(4'h1, 1'b0, 1'b0);
        check_eq("readA_mem7", {8'd0, dut.memoria.memoria[7]}, 16'h00CC);
        do_instr(4'h2, 1'b0, 1'b0);
        check_eq("loadB_b", {8'd0, dut.reg_b_q}, 16'h00CC);

        // NOP opcode 4'hF: handshake only, nothing changes.
        do_instr(4'h3, 1'b0, 1'b0);
        check_mem("nop_mem");

        // Illegal token in IDLE must not start a fetch.
        ph0 = 2'b11;
        repeat (4) @(negedge clk);
        check_eq("illegal_ph0", {15'd0, mem_addr_ack}, 16'h0000);
        check_eq("illegal_state", {13'd0, dut.state_q}, {13'd0, cpu_pkg::ST_IDLE});
        ph0 = 2'b00;
        @(negedge clk);

        // Both tokens at once: fetch first, execute afterwards.
        do_instr(4'h5, 1'b1, 1'b0);

        // READ_A (mem[4]=0x42 stores A to mem[2]) then reset in HOLD.
        do_instr(4'h4, 1'b0, 1'b1);
        check_mem("midop_mem");

        // Randomized programs.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            case ($urandom_range(0, 3))
                0: v[7:4] = 4'b1000;
                1: v[7:4] = 4'b1001;
                2: v[7:4] = 4'b0100;
                default: ;
            endcase
            poke(4'(i), v);
        end
        for (int n = 0; n < 40; n++) begin
            do_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
        end
        check_mem("final_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
